// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM states, BCD digit
// geometry and the 4-digit BCD increment helper.
package stopwatch_pkg;

    localparam int DIGIT_W    = 4;
    localparam int BCD_MAX    = 9;
    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd_t;

    // Ripple a +1 through the digits; all-nines wraps to all-zeros.
    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t r;
        logic c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (v[i] == DIGIT_W'(BCD_MAX)) begin
                    r[i] = '0;
                end else begin
                    r[i] = v[i] + 1'b1;
                    c    = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Button conditioning: 2-FF synchronizer, optional debounce (STOPWATCH_DEBOUNCE_EN),
// rising-edge detector producing a one-cycle pulse.
module btn_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic s1, s2, lvl, lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          stable;

    // Accept a new level only after it has disagreed with the accepted one long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    assign lvl = stable;
`else
    assign lvl = s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lvl_d <= 1'b0;
        else     lvl_d <= lvl;
    end

    assign pulse = lvl & ~lvl_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/STOP/LAP FSM, 0.01 s BCD counter with lap snapshot,
// and display scan strobe. Define STOPWATCH_DEBOUNCE_EN to debounce the buttons.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_PER_TICK    = 500000,
    parameter int CLK_PER_SCAN    = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_ss,
    input  logic               btn_lc,
    output logic [DIGIT_W-1:0] disp0,
    output logic [DIGIT_W-1:0] disp1,
    output logic [DIGIT_W-1:0] disp2,
    output logic [DIGIT_W-1:0] disp3,
    output logic               scan_en,
    output logic               running,
    output logic               lap_active
);

    localparam int TW = $clog2(CLK_PER_TICK);
    localparam int SW = $clog2(CLK_PER_SCAN);

    state_t          state, state_nx;
    logic            ss_p, lc_p, active, tick;
    logic [TW-1:0]   tick_cnt;
    logic [SW-1:0]   scan_cnt;
    bcd_t            bcd, snap, shown;

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
        .clk(clk), .rst(rst), .btn(btn_ss), .pulse(ss_p)
    );
    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lc (
        .clk(clk), .rst(rst), .btn(btn_lc), .pulse(lc_p)
    );

    // Start/stop wins over lap/clear when both arrive together.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ss_p) state_nx = RUN;
            RUN:     if (ss_p) state_nx = STOP; else if (lc_p) state_nx = LAP;
            LAP:     if (ss_p) state_nx = STOP; else if (lc_p) state_nx = RUN;
            STOP:    if (ss_p) state_nx = RUN;  else if (lc_p) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign active = (state == RUN) || (state == LAP);
    assign tick   = active && (tick_cnt == TW'(CLK_PER_TICK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Tick is judged on the current state, so one landing on an exit edge still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd      <= '0;
            tick_cnt <= '0;
        end else if (state_nx == IDLE) begin
            bcd      <= '0;
            tick_cnt <= '0;
        end else begin
            if (tick)   bcd      <= bcd_inc(bcd);
            if (active) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  snap <= '0;
        else if (state == RUN && state_nx == LAP) snap <= bcd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_en  <= 1'b0;
        end else begin
            scan_en  <= (scan_cnt == SW'(CLK_PER_SCAN - 1));
            scan_cnt <= (scan_cnt == SW'(CLK_PER_SCAN - 1)) ? '0 : scan_cnt + 1'b1;
        end
    end

    assign shown      = (state == LAP) ? snap : bcd;
    assign disp0      = shown[0];
    assign disp1      = shown[1];
    assign disp2      = shown[2];
    assign disp3      = shown[3];
    assign running    = active;
    assign lap_active = (state == LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (CLK_PER_TICK=4, CLK_PER_SCAN=3, no debounce):
// a centisecond-integer reference model pushes expected outputs each edge, popped at negedge.
module tb_stopwatch_ctrl;

    localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;

    typedef struct {
        logic [15:0] disp;
        logic        run;
        logic        lap;
        logic        scan;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lc = 1'b0;
    logic [3:0] disp0, disp1, disp2, disp3;
    logic       scan_en, running, lap_active;
    logic [15:0] disp_all;

    int nchk = 0;
    int nerr = 0;
    exp_t sbq[$];

    // reference model state
    int       mst, mcnt, msnap, mpc, msc;
    logic     mscan;
    logic [2:0] mss, mlc;

    stopwatch_ctrl #(.CLK_PER_TICK(4), .CLK_PER_SCAN(3), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lc(btn_lc),
        .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
        .scan_en(scan_en), .running(running), .lap_active(lap_active)
    );

    always #5 clk = ~clk;
    assign disp_all = {disp3, disp2, disp1, disp0};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_dig(input int c);
        logic [15:0] v;
        v[3:0]   = 4'(c % 10);
        v[7:4]   = 4'((c / 10) % 10);
        v[11:8]  = 4'((c / 100) % 10);
        v[15:12] = 4'((c / 1000) % 10);
        return v;
    endfunction

    task automatic mreset();
        mst = M_IDLE; mcnt = 0; msnap = 0; mpc = 0; msc = 0;
        mscan = 1'b0; mss = '0; mlc = '0;
    endtask

    // One clock: advance model at posedge, push expectation, pop and compare at negedge.
    task automatic step();
        exp_t e, g;
        logic ssp, lcp, tk;
        int nst;
        @(posedge clk);
        if (rst) begin
            mreset();
        end else begin
            ssp = mss[1] & ~mss[2];
            lcp = mlc[1] & ~mlc[2];
            mss = {mss[1:0], btn_ss};
            mlc = {mlc[1:0], btn_lc};
            tk  = (mst == M_RUN || mst == M_LAP) && mpc == 3;
            nst = mst;
            case (mst)
                M_IDLE: if (ssp) nst = M_RUN;
                M_RUN:  if (ssp) nst = M_STOP; else if (lcp) nst = M_LAP;
                M_LAP:  if (ssp) nst = M_STOP; else if (lcp) nst = M_RUN;
                default: if (ssp) nst = M_RUN; else if (lcp) nst = M_IDLE;
            endcase
            if (mst == M_RUN && nst == M_LAP) msnap = mcnt;
            if (tk) mcnt = (mcnt + 1) % 10000;
            if (mst == M_RUN || mst == M_LAP) mpc = (mpc + 1) % 4;
            if (nst == M_IDLE) begin mcnt = 0; mpc = 0; end
            mscan = (msc == 2);
            msc   = (msc + 1) % 3;
            mst   = nst;
        end
        e.disp = to_dig(mst == M_LAP ? msnap : mcnt);
        e.run  = (mst == M_RUN || mst == M_LAP);
        e.lap  = (mst == M_LAP);
        e.scan = mscan;
        sbq.push_back(e);
        @(negedge clk);
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sbq.pop_front();
            chk("disp",    32'(disp_all),   32'(g.disp));
            chk("running", 32'(running),    32'(g.run));
            chk("lap",     32'(lap_active), 32'(g.lap));
            chk("scan_en", 32'(scan_en),    32'(g.scan));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic ss, input logic lc);
        btn_ss = ss; btn_lc = lc;
        step();
        btn_ss = 1'b0; btn_lc = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_disp"}, 32'(disp_all), 32'd0);
        chk({tag, "_run"},  32'(running),  32'd0);
        chk({tag, "_lap"},  32'(lap_active), 32'd0);
        chk({tag, "_scan"}, 32'(scan_en),  32'd0);
    endtask

    initial begin
        mreset();
        #2;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        steps(4);

        // start: running after 3 edges, then 10 ticks in 40 cycles
        press(1'b1, 1'b0);
        step();
        chk("start_lat_early", 32'(running), 32'd0);
        step();
        chk("start_lat", 32'(running), 32'd1);
        steps(40);
        chk("ten_ticks", 32'(disp_all), 32'h0010);

        // stop holds display, clear returns to zero
        press(1'b1, 1'b0);
        steps(2);
        chk("stopped", 32'(running), 32'd0);
        steps(100);
        chk("stop_hold", 32'(disp_all), 32'h0010);
        press(1'b0, 1'b1);
        steps(2);
        chk("clear", 32'(disp_all), 32'h0000);

        // lap: freeze at 00.05 while live count reaches 00.09
        press(1'b1, 1'b0);
        for (int i = 0; i < 200 && !(mst == M_RUN && mcnt == 5 && mpc == 0); i++) step();
        chk("lap_setup", 32'(mcnt), 32'd5);
        press(1'b0, 1'b1);
        steps(15);
        chk("lap_active", 32'(lap_active), 32'd1);
        chk("lap_frozen", 32'(disp_all), 32'h0005);
        press(1'b0, 1'b1);
        steps(2);
        chk("lap_exit", 32'(lap_active), 32'd0);
        chk("lap_live", 32'(disp_all), 32'h0009);

        // simultaneous presses in RUN: start/stop wins
        press(1'b1, 1'b1);
        steps(2);
        chk("both_run", 32'(running), 32'd0);
        chk("both_lap", 32'(lap_active), 32'd0);
        steps(3);
        press(1'b0, 1'b1);
        steps(2);
        chk("clear2", 32'(disp_all), 32'h0000);

        // run up to 99.99 and wrap
        press(1'b1, 1'b0);
        for (int i = 0; i < 45000 && mcnt != 9999; i++) step();
        chk("max", 32'(disp_all), 32'h9999);
        for (int i = 0; i < 8 && mcnt != 0; i++) step();
        chk("wrap", 32'(disp_all), 32'h0000);
        chk("wrap_run", 32'(running), 32'd1);
        steps(9);
        chk("after_wrap", 32'(disp_all), 32'h0002);

        // asynchronous reset mid-run
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        mreset();
        steps(2);
        rst = 1'b0;
        steps(10);
        chk("no_resume", 32'(running), 32'd0);
        press(1'b1, 1'b0);
        steps(2);
        chk("resume", 32'(running), 32'd1);
        steps(8);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_PER_TICK, default 500000, clk cycles per 0.01 s count tick; minimum 2.
REQ-002 Parameter CLK_PER_SCAN, default 50000, clk cycles per display digit-scan enable pulse; minimum 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000, stable-level cycles required by the debounce filter.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 btn_ss  input  1  raw start/stop button, asynchronous to clk, active-high.
REQ-007 btn_lc  input  1  raw lap/clear button, asynchronous to clk, active-high.
REQ-008 disp0..disp3  output  4 each  BCD digits to the display mux (disp0 = 1/100 s, disp1 = 1/10 s, disp2 = seconds ones, disp3 = seconds tens).
REQ-009 scan_en  output  1  one-cycle pulse advancing the display mux digit counter.
REQ-010 running  output  1  high in RUN or LAP.
REQ-011 lap_active  output  1  high in LAP.

Function
REQ-012 Each button SHALL pass through a 2-FF synchronizer and a rising-edge detector, giving one-cycle pulses ss_p and lc_p.
REQ-013 FSM states IDLE, RUN, STOP, LAP; IDLE: ss_p -> RUN. RUN: ss_p -> STOP, lc_p -> LAP. LAP: ss_p -> STOP, lc_p -> RUN. STOP: ss_p -> RUN, lc_p -> IDLE.
REQ-014 When ss_p and lc_p are high in the same cycle, ss_p SHALL take priority and lc_p SHALL be discarded.
REQ-015 State change SHALL be visible 3 clk edges after the first edge sampling a raw button high (debounce disabled).
REQ-016 Tick prescaler SHALL count 0..CLK_PER_TICK-1 in RUN and LAP, hold in STOP, clear to 0 in IDLE; tick fires when count = CLK_PER_TICK-1.
REQ-017 On tick, the 4-digit BCD counter SHALL increment with per-digit carry at 9; 99.99 SHALL wrap to 00.00.
REQ-018 Entering IDLE SHALL clear the BCD counter and the prescaler in the same edge as the state change.
REQ-019 disp0..3 SHALL show the live counter in IDLE, RUN, STOP, and a snapshot in LAP captured on the RUN->LAP edge; the live counter keeps counting in LAP.
REQ-020 LAP->STOP SHALL display the live (stopped) counter immediately.
REQ-021 scan_en SHALL be generated by a free-running prescaler, high one cycle every CLK_PER_SCAN cycles in all states.
REQ-022 A tick coinciding with a state change out of RUN/LAP SHALL still be applied.

Reset
REQ-023 rst SHALL force state IDLE, disp0..3 = 0, BCD counter = 0, snapshot = 0, both prescalers = 0, scan_en = 0, running = 0, lap_active = 0, synchronizers and edge detectors = 0.
REQ-024 Reset asserted mid-run SHALL take effect immediately; counting resumes only after a new ss_p following deassertion.

Configuration
REQ-025 With STOPWATCH_DEBOUNCE_EN defined, each synchronized button SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal samples, adding that latency before the edge detector.
REQ-026 Without STOPWATCH_DEBOUNCE_EN, synchronizer output feeds the edge detector directly and DEBOUNCE_CYCLES is unused.

Structure
REQ-027 Shared package stopwatch_pkg SHALL hold the state enum, BCD_MAX = 9, and digit width 4.
REQ-028 Button conditioning (sync, optional debounce, edge detect) SHALL be sub-module btn_cond, instantiated twice.

Verification (CLK_PER_TICK=4, CLK_PER_SCAN=3, debounce off)
REQ-029 Reset, press btn_ss -> running = 1 after 3 edges; after 40 more cycles disp = 0,1,0,0 (10 ticks).
REQ-030 Preload via run to 99.98, two ticks -> 99.99 then 00.00, no X, no stall.
REQ-031 RUN at 00.05, press btn_lc -> lap_active = 1, disp frozen at 00.05 while live counter reaches 00.09 in 16 cycles; btn_lc again -> disp shows 00.09.
REQ-032 RUN, press btn_ss -> STOP, disp constant for 100 cycles; btn_lc -> IDLE, disp = 00.00.
REQ-033 btn_ss and btn_lc rise on same cycle in RUN -> STOP, lap_active stays 0.
REQ-034 Any state, scan_en pulses every 3 cycles; rst asserted mid-RUN -> all outputs 0 asynchronously.
